// File: rtl/ripple_carry_adder_nb_pkg.sv
// Shared constants for the ripple-carry adder slice.
// DATA_WIDTH is the default operand width used by the ALU instantiation.
package ripple_carry_adder_nb_pkg;

  localparam int unsigned DATA_WIDTH = 32;

endpackage : ripple_carry_adder_nb_pkg

// File: rtl/ripple_carry_adder_nb_if.sv
// Operand/result bundle for ripple_carry_adder_nb.
//   a, b : N-bit operands      ci : carry-in to bit 0
//   s    : N-bit sum           co : carry-out of bit N-1
// master drives operands and reads results; slave is the adder side.
interface ripple_carry_adder_nb_if
  import ripple_carry_adder_nb_pkg::*;
#(
  parameter int unsigned N = DATA_WIDTH
);

  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic [N-1:0] s;
  logic         co;

  modport master (output a, output b, output ci, input s, input co);
  modport slave  (input a, input b, input ci, output s, output co);

endinterface : ripple_carry_adder_nb_if

// File: rtl/ripple_carry_adder_nb_full_adder.sv
// Single-bit full adder, one stage of the ripple chain.
//   a, b : operand bits   ci : carry in
//   s    : sum bit        co : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder

// File: rtl/ripple_carry_adder_nb.sv
// N-bit ripple-carry adder with a registered sum/carry output stage.
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous active-low reset, clears s/co
//   bus    : slave side of ripple_carry_adder_nb_if (a, b, ci in; s, co out)
// Result {co, s} = a + b + ci appears one cycle after the operands.
module ripple_carry_adder_nb
  import ripple_carry_adder_nb_pkg::*;
#(
  parameter int unsigned N = DATA_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  ripple_carry_adder_nb_if.slave   bus
);

  logic [N:0]   c;
  logic [N-1:0] sum_c;
  logic [N-1:0] s_d, s_q;
  logic         co_d, co_q;

  assign c[0] = bus.ci;

  // Strictly bit-serial carry chain, LSB to MSB.
  for (genvar i = 0; i < int'(N); i++) begin : g_fa
    full_adder u_fa (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (c[i]),
      .s  (sum_c[i]),
      .co (c[i+1])
    );
  end

  assign s_d  = sum_c;
  assign co_d = c[N];

  // Output register loads every edge; no enable.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign bus.s  = s_q;
  assign bus.co = co_q;

endmodule : ripple_carry_adder_nb

// File: tb/tb_ripple_carry_adder_nb.sv
// Self-checking bench for ripple_carry_adder_nb at N = 32 and N = 8.
module tb_ripple_carry_adder_nb;

  logic clk;
  logic rstn;

  int checks;
  int failures;

  logic [32:0] q32[$];
  logic [8:0]  q8[$];

  ripple_carry_adder_nb_if #(.N(32)) bus32 ();
  ripple_carry_adder_nb_if #(.N(8))  bus8 ();

  ripple_carry_adder_nb #(.N(32)) u_dut32 (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus32.slave)
  );

  ripple_carry_adder_nb #(.N(8)) u_dut8 (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Drive both DUTs (8-bit DUT gets the low byte) and record expectations.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [7:0] a8, b8;
    a8 = a[7:0];
    b8 = b[7:0];
    bus32.a  = a;
    bus32.b  = b;
    bus32.ci = ci;
    bus8.a   = a8;
    bus8.b   = b8;
    bus8.ci  = ci;
    q32.push_back(33'(a) + 33'(b) + 33'(ci));
    q8.push_back(9'(a8) + 9'(b8) + 9'(ci));
  endtask

  // Advance one edge, then compare the oldest expectation against each DUT.
  task automatic tick(input string tag);
    logic [32:0] e32;
    logic [8:0]  e8;
    @(posedge clk);
    #1;
    if (q32.size() == 0 || q8.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e32 = q32.pop_front();
      e8  = q8.pop_front();
      check({tag, "_n32"}, {bus32.co, bus32.s}, e32);
      check({tag, "_n8"}, 33'({bus8.co, bus8.s}), 33'(e8));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    bus32.a  = 32'hFFFF_FFFF;
    bus32.b  = 32'd1;
    bus32.ci = 1'b0;
    bus8.a   = 8'hFF;
    bus8.b   = 8'd1;
    bus8.ci  = 1'b0;

    // Held in reset: outputs stay 0 across clock edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_n32", {bus32.co, bus32.s}, 33'd0);
      check("reset_n8", 33'({bus8.co, bus8.s}), 33'd0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // Directed cases.
    drive(32'd5, 32'd7, 1'b0);                   tick("add_5_7");
    drive(32'd5, 32'd7, 1'b1);                   tick("add_5_7_ci");
    drive(32'hFFFF_FFFF, 32'd1, 1'b0);           tick("wrap_b1");
    drive(32'hFFFF_FFFF, 32'd0, 1'b1);           tick("wrap_ci");
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);   tick("max_sum");
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);   tick("msb_pair");
    drive(32'h0000_0080, 32'h0000_0080, 1'b0);   tick("msb8_pair");

    // Back-to-back pipelining.
    drive(32'd1, 32'd2, 1'b0);                   tick("pipe_3");
    drive(32'd3, 32'd4, 1'b0);                   tick("pipe_7");
    drive(32'd10, 32'd20, 1'b0);                 tick("pipe_30");

    // Mid-operation reset: outputs clear immediately, then the held inputs are captured.
    drive(32'd100, 32'd200, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_n32", {bus32.co, bus32.s}, 33'd0);
    check("midrst_n8", 33'({bus8.co, bus8.s}), 33'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick("post_rst");

    // Randomised operands, one new pair every cycle.
    for (int i = 0; i < 10000; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ripple_carry_adder_nb

// File: doc/ripple_carry_adder_nb.md
# ripple_carry_adder_nb

Parameterised N-bit ripple-carry adder with a registered sum/carry output stage. It is the adder datapath instantiated by the `jedro_1_alu` core ALU: operands `opa_i`/`opb_i` feed `a`/`b`, `ci` is tied low, and `s` drives `res_o`. The output register gives one cycle of latency, so the result is valid in the same cycle the ALU raises `res_ready_o`.

## Interface
- `N`, default 32 (ALU passes `DATA_WIDTH`), operand and sum width; legal range 1 and up.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rstn_i`  in  1  reset, asynchronous and active-low.
- `ci`  in  1  carry-in to bit 0.
- `a`  in  N  operand A, unsigned/two's-complement agnostic.
- `b`  in  N  operand B.
- `s`  out  N  registered sum, `(a + b + ci) mod 2^N`.
- `co`  out  1  registered carry-out of bit N-1.

## Operation
- Combinational chain of N full adders:
  - Stage i computes `sum_i = a[i] ^ b[i] ^ c[i]`.
  - Stage i computes `c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))`.
  - `c[0] = ci`.
- The carry propagates strictly bit-serially from LSB to MSB. No lookahead or carry-select; synthesis is not to restructure it by design intent.
- `{co, s}` equals the (N+1)-bit value `a + b + ci`.
- Wrap-around: all-ones + 1 gives `s = 0`, `co = 1`. No overflow or saturation flag; signed overflow is the caller's concern.
- No enable: the output register loads every clock edge while out of reset.
- X/Z on inputs is not filtered; it propagates to the outputs.

## Timing
- While `rstn_i` is low, `s = 0` and `co = 0`, regardless of clock. Assertion clears the outputs immediately.
- Deassertion is synchronised externally. The first edge with `rstn_i` high captures the current inputs.
- Latency is exactly 1 cycle: inputs present before edge k appear on `s`/`co` after edge k.
- Throughput is one addition per cycle; back-to-back operands are fully pipelined.
- Reset mid-operation: the in-flight result is discarded and the outputs read 0. The next result appears one cycle after the first edge following release.
- Critical path: N full-adder carry stages plus register setup. The clock period must cover the worst-case full-carry ripple, e.g. all-ones + 1.

## Structure
- No package constants are needed beyond the existing `DATA_WIDTH` in `jedro_1_defines.v`, which the instantiating ALU passes as `N`.
- One sub-module, `full_adder` (ports `a`, `b`, `ci`, `s`, `co`), instantiated N times in a generate loop.
- The carry vector `c[N:0]` is internal; `c[N]` feeds the `co` register.
- The output register sits in the top module: one always block sensitive to `posedge clk_i` or `negedge rstn_i`.

## Test plan
- Reset: hold `rstn_i` = 0, drive `a = 0xFFFFFFFF`, `b = 1`, toggle the clock -> `s = 0`, `co = 0` throughout.
- Basic add (N = 32): `a = 5`, `b = 7`, `ci = 0` -> after 1 edge, `s = 12`, `co = 0`. Same operands with `ci = 1` -> `s = 13`.
- Full ripple and wrap-around: `a = 0xFFFFFFFF`, `b = 1`, `ci = 0` -> `s = 0x00000000`, `co = 1`. Also `a = 0xFFFFFFFF`, `b = 0`, `ci = 1` -> `s = 0`, `co = 1`.
- Maximum sum: `a = b = 0xFFFFFFFF`, `ci = 1` -> `s = 0xFFFFFFFF`, `co = 1`. Also `a = 0x80000000`, `b = 0x80000000` -> `s = 0`, `co = 1`.
- Pipelining and mid-operation reset:
  - Drive (1, 2), then (3, 4), then (10, 20) on consecutive cycles -> `s` reads 3, 7, 30 on consecutive cycles.
  - Pulse `rstn_i` low between edges -> `s` goes to 0 immediately.
- Randomised: 10k random `a`, `b`, `ci` with N = 32 and N = 8 -> `{co, s} == a + b + ci`, one cycle delayed.
